// File: rtl/demux_rr_sched_pkg.sv
// Shared definitions for the round-robin 1-to-4 demux scheduler:
// FSM state encodings, lane count, select width and a one-hot helper.
package demux_rr_sched_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_OUT-1:0] lane_onehot(input sel_t s);
    return {{(N_OUT-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/demux_rr_sched_if.sv
// Producer/consumer bus of the demux scheduler; slave = scheduler side, master = environment side.
interface demux_rr_sched_if #(
  parameter int W = 1
);
  import demux_rr_sched_pkg::*;

  logic [W-1:0]       D;
  logic               D_valid;
  logic               D_ready;
  logic [N_OUT-1:0]   dest_mask;
  logic [N_OUT*W-1:0] Y;
  logic [N_OUT-1:0]   Y_valid;
  logic [N_OUT-1:0]   Y_ready;
  sel_t               S;
  logic               drop;

  modport slave (
    input  D, D_valid, dest_mask, Y_ready,
    output D_ready, Y, Y_valid, S, drop
  );

  modport master (
    output D, D_valid, dest_mask, Y_ready,
    input  D_ready, Y, Y_valid, S, drop
  );

endinterface

// File: rtl/demux_rr_sched_rr_next4.sv
// Combinational round-robin pick: first enabled lane scanning s+1, s+2, s+3, s (mod 4).
// If nothing is enabled the select is returned unchanged and any_o is low.
module rr_next4
  import demux_rr_sched_pkg::*;
(
  input  sel_t             s_i,
  input  logic [N_OUT-1:0] mask_i,
  output sel_t             next_o,
  output logic             any_o
);

  sel_t idx;

  always_comb begin
    next_o = s_i;
    any_o  = |mask_i;
    idx    = s_i;
    // Walk from the farthest offset down so the nearest enabled lane wins.
    for (int k = N_OUT; k >= 1; k--) begin
      idx = s_i + sel_t'(k);
      if (mask_i[idx]) next_o = idx;
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler + output stage for a 1-to-4 demux; 1-entry buffer, word on Y the cycle after accept.
// D_ready follows Y_ready of the held lane so back-to-back words flow at 1/cycle; DEMUX_TIMEOUT_EN adds stall drop.
module demux_rr_sched
  import demux_rr_sched_pkg::*;
#(
  parameter int W = 1
`ifdef DEMUX_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input logic               clk,
  input logic               rst,
  demux_rr_sched_if.slave   bus
);

  state_e         state_q, state_d;
  sel_t           S_q, S_d;
  logic [W-1:0]   buf_q, buf_d;
  sel_t           nxt_sel;
  logic           any_en;
  logic           hold;
  logic           d_ready;
  logic           in_xfer;
  logic           out_xfer;
  logic           timeout;

  rr_next4 u_rr (
    .s_i    (S_q),
    .mask_i (bus.dest_mask),
    .next_o (nxt_sel),
    .any_o  (any_en)
  );

  assign hold     = (state_q == ST_HOLD);
  assign out_xfer = hold & bus.Y_ready[S_q];
  assign in_xfer  = bus.D_valid & d_ready;

  always_comb begin
    d_ready = 1'b0;
    case (state_q)
      ST_IDLE: d_ready = any_en;
      ST_HOLD: d_ready = bus.Y_ready[S_q] & any_en;
      default: d_ready = 1'b0;
    endcase
    // Reset is asynchronous, so the handshake must be blocked combinationally too.
    if (rst) d_ready = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    S_d     = S_q;
    buf_d   = buf_q;
    if (in_xfer) begin
      state_d = ST_HOLD;
      S_d     = nxt_sel;
      buf_d   = bus.D;
    end else if (out_xfer || timeout) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      S_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      S_q     <= S_d;
      buf_q   <= buf_d;
    end
  end

`ifdef DEMUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  // The TIMEOUT-th consecutive stalled cycle discards the word at the next edge.
  assign timeout = hold & ~bus.Y_ready[S_q] & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    drop_d = timeout;
    cnt_d  = cnt_q;
    if (!hold || in_xfer || out_xfer || timeout) cnt_d = '0;
    else                                          cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  assign bus.drop = drop_q;
`else
  assign timeout  = 1'b0;
  assign bus.drop = 1'b0;
`endif

  always_comb begin
    bus.Y       = '0;
    bus.Y_valid = '0;
    if (hold) begin
      bus.Y_valid                = lane_onehot(S_q);
      bus.Y[int'(S_q) * W +: W]  = buf_q;
    end
  end

  assign bus.D_ready = d_ready;
  assign bus.S       = S_q;

endmodule
